int_result_writer: RTL and testbench
====================================

Name: int_result_writer

Overview:
- Producer-side counterpart to EX-stage operand forwarding, for integer results from long-latency units (divider, multi-cycle FP-to-int).
- Keeps a per-register pending scoreboard and buffers completions in a FIFO.
- Drains the FIFO into the integer regfile write port only in cycles the main pipeline leaves free.
- Publishes each write as a registered forward/writeback beat so forwarding and hazard logic can bypass or stall on it.

Parameters:
- XLEN, 32, data width.
- DEPTH, 4, completion FIFO entries; also the cap on outstanding issued ops (power of 2, ≥2).
- STARVE_LIMIT, 8, consecutive starved cycles before a write-slot steal is requested (≥1).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_issue_valid  in  1  long-latency op with integer rd leaves EX this cycle
- i_issue_rd  in  5  destination register of issuing op
- o_issue_ready  out  1  issue accepted this cycle (combinational)
- i_rs1  in  5  source reg 1 of instruction in ID
- i_rs2  in  5  source reg 2 of instruction in ID
- o_rs1_pending  out  1  i_rs1 has an unwritten long-latency result (combinational)
- o_rs2_pending  out  1  same for i_rs2
- i_cpl_valid  in  1  unit completion
- i_cpl_rd  in  5  completing rd
- i_cpl_data  in  XLEN  completing data
- i_wb_slot_free  in  1  main pipeline does not use regfile write port this cycle
- o_wb_valid  out  1  regfile write / forward beat (registered)
- o_wb_rd  out  5  write register (registered)
- o_wb_data  out  XLEN  write data (registered)
- o_wb_steal_req  out  1  request hazard unit to bubble one cycle to free the write slot (registered)
- o_outstanding  out  $clog2(DEPTH+1)  issued-not-yet-written count (registered)

Behaviour:
- Reset (async, i_rst_n=0):
  - pending[31:0]=0, FIFO empty, outstanding=0, starve counter=0.
  - o_wb_valid=0, o_wb_rd=0, o_wb_data=0, o_wb_steal_req=0.
  - Reset mid-operation discards all queued results and pending bits.
- Issue:
  - o_issue_ready = (outstanding<DEPTH) && !(i_issue_rd!=0 && pending[i_issue_rd]). A WAW on a pending rd stalls issue.
  - Accepted issue with rd!=0 sets pending[rd] and increments outstanding.
  - rd=0 issues are accepted, not tracked, no count; their completions are dropped on FIFO push.
- Lookup: o_rsN_pending = (i_rsN!=0) && pending[i_rsN]. x0 is never pending.
- Completion:
  - i_cpl_valid pushes {rd,data} into the FIFO, order preserved.
  - Because outstanding≤DEPTH, the FIFO cannot overflow. A push while full is a protocol error: the push is dropped, with a simulation-only $error.
- Drain:
  - Each cycle, if FIFO non-empty and i_wb_slot_free=1, pop the head and register it onto o_wb_*, with o_wb_valid=1 next cycle. Otherwise o_wb_valid=0 next cycle.
  - o_wb_rd/o_wb_data hold their last value when invalid.
- Retire: on the same edge that loads a beat into o_wb_*, clear pending[rd] and decrement outstanding.
- Latency: completion at cycle N → FIFO at N+1 → o_wb_valid at N+2 when slot free both cycles.
- Simultaneous events:
  - Issue and retire in the same cycle: outstanding is unchanged; pending[retire rd] is cleared.
  - WAW rule prevents an issue rd equal to the retire rd while pending. Issue can re-use that rd the cycle after pending clears.
  - Push and pop in the same cycle are allowed when FIFO non-empty.
- Starvation:
  - The counter increments each cycle FIFO non-empty && !i_wb_slot_free.
  - It clears on any pop or when the FIFO is empty.
  - o_wb_steal_req=1 while counter≥STARVE_LIMIT; it deasserts the cycle after the pop.
  - The counter saturates and does not wrap.
- FIFO pointers are $clog2(DEPTH) bits plus a wrap bit and wrap naturally at DEPTH.

Optional Feature:
- FROST_INT_WB_BYPASS_EN defined: when FIFO empty, i_cpl_valid=1, i_cpl_rd!=0 and i_wb_slot_free=1, the completion loads o_wb_* directly on that edge (latency 1), skipping the FIFO. Retire rules are unchanged.
- Not defined: all completions pass through the FIFO (latency 2 minimum).

Test Plan:
- Reset/lookup: after reset all outputs 0. Issue rd=5, then i_rs1=5 → o_rs1_pending=1; i_rs2=0 → o_rs2_pending=0.
- Basic writeback: issue rd=5, complete rd=5 data=0xDEADBEEF at cycle N with slot free → o_wb_valid=1, rd=5, data=0xDEADBEEF at N+2 (N+1 with FROST_INT_WB_BYPASS_EN). pending[5]=0 and outstanding=0 afterwards.
- Capacity/WAW:
  - 4 issues rd=1..4 → o_issue_ready=0 at outstanding=4.
  - Issue rd=2 again while pending → o_issue_ready=0.
  - After rd=2 retires → ready=1.
- Starvation: one queued result, i_wb_slot_free=0 for 8 cycles → o_wb_steal_req=1 after 8th cycle. Slot free → pop, steal_req=0 next cycle.
- Ordering: completions rd=7 (0x1), rd=8 (0x2), rd=9 (0x3) back-to-back with slot toggling 1,0,1,1 → beats emitted strictly 7,8,9 with matching data.
- Reset mid-operation: 3 queued results, assert i_rst_n=0 asynchronously → o_wb_valid=0, outstanding=0, all pending clear immediately; no beats after release.

Source files
------------

// File: rtl/int_result_writer.sv
// Long-latency integer result writer: pending scoreboard, completion FIFO, and idle-slot regfile writeback.
// FROST_INT_WB_BYPASS_EN: a completion that finds the FIFO empty and the write slot free is written directly.
module int_result_writer #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_issue_valid,
  input  logic [4:0]                 i_issue_rd,
  output logic                       o_issue_ready,
  input  logic [4:0]                 i_rs1,
  input  logic [4:0]                 i_rs2,
  output logic                       o_rs1_pending,
  output logic                       o_rs2_pending,
  input  logic                       i_cpl_valid,
  input  logic [4:0]                 i_cpl_rd,
  input  logic [XLEN-1:0]            i_cpl_data,
  input  logic                       i_wb_slot_free,
  output logic                       o_wb_valid,
  output logic [4:0]                 o_wb_rd,
  output logic [XLEN-1:0]            o_wb_data,
  output logic                       o_wb_steal_req,
  output logic [$clog2(DEPTH+1)-1:0] o_outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam logic [OW-1:0] OUT_MAX    = OW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [31:0]      pending, pending_next;
  logic [4:0]       rd_mem   [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [SW-1:0]    starve_cnt, starve_next;
  logic             fifo_empty, fifo_full;
  logic             bypass, push, pop, load, issue_track;
  logic [4:0]       load_rd;
  logic [XLEN-1:0]  load_data;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Issue handshake: an op transfers on a cycle where i_issue_valid && o_issue_ready;
  // ready never depends on valid, and a stalled op simply holds valid until ready rises.
  assign o_issue_ready = (o_outstanding < OUT_MAX) &&
                         !((i_issue_rd != 5'd0) && pending[i_issue_rd]);
  assign issue_track   = i_issue_valid && o_issue_ready && (i_issue_rd != 5'd0);

  assign o_rs1_pending = (i_rs1 != 5'd0) && pending[i_rs1];
  assign o_rs2_pending = (i_rs2 != 5'd0) && pending[i_rs2];

`ifdef FROST_INT_WB_BYPASS_EN
  assign bypass = fifo_empty && i_cpl_valid && (i_cpl_rd != 5'd0) && i_wb_slot_free;
`else
  assign bypass = 1'b0;
`endif

  // x0 completions are discarded here rather than occupying a FIFO slot.
  assign push      = i_cpl_valid && (i_cpl_rd != 5'd0) && !fifo_full && !bypass;
  assign pop       = !fifo_empty && i_wb_slot_free;
  assign load      = pop || bypass;
  assign load_rd   = bypass ? i_cpl_rd   : rd_mem[rd_ptr[AW-1:0]];
  assign load_data = bypass ? i_cpl_data : data_mem[rd_ptr[AW-1:0]];

  always_comb begin
    pending_next = pending;
    if (load)        pending_next[load_rd]    = 1'b0;
    if (issue_track) pending_next[i_issue_rd] = 1'b1;
  end

  always_comb begin
    starve_next = starve_cnt;
    if (fifo_empty || pop)            starve_next = '0;
    else if (starve_cnt != STARVE_MAX) starve_next = starve_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      rd_mem[wr_ptr[AW-1:0]]   <= i_cpl_rd;
      data_mem[wr_ptr[AW-1:0]] <= i_cpl_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      starve_cnt     <= '0;
      o_outstanding  <= '0;
      o_wb_valid     <= 1'b0;
      o_wb_rd        <= '0;
      o_wb_data      <= '0;
      o_wb_steal_req <= 1'b0;
    end else begin
      pending        <= pending_next;
      starve_cnt     <= starve_next;
      o_wb_steal_req <= (starve_next >= STARVE_MAX);
      o_wb_valid     <= load;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (load) begin
        o_wb_rd   <= load_rd;
        o_wb_data <= load_data;
      end
      if (issue_track && !load)
        o_outstanding <= o_outstanding + 1'b1;
      else if (!issue_track && load && (o_outstanding != '0))
        o_outstanding <= o_outstanding - 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_cpl_valid && (i_cpl_rd != 5'd0) && fifo_full && !bypass)
      $error("int_result_writer: completion rd=%0d dropped, FIFO full", i_cpl_rd);
  end
`endif

endmodule

// File: tb/tb_int_result_writer.sv
// Directed bench for int_result_writer: scoreboarded writeback beats plus latency, capacity and starvation checks.
module tb_int_result_writer;

  localparam int XLEN = 32;

  logic            i_clk;
  logic            i_rst_n;
  logic            i_issue_valid;
  logic [4:0]      i_issue_rd;
  logic            o_issue_ready;
  logic [4:0]      i_rs1, i_rs2;
  logic            o_rs1_pending, o_rs2_pending;
  logic            i_cpl_valid;
  logic [4:0]      i_cpl_rd;
  logic [XLEN-1:0] i_cpl_data;
  logic            i_wb_slot_free;
  logic            o_wb_valid;
  logic [4:0]      o_wb_rd;
  logic [XLEN-1:0] o_wb_data;
  logic            o_wb_steal_req;
  logic [2:0]      o_outstanding;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  int_result_writer #(.XLEN(XLEN), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .o_issue_ready(o_issue_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .o_rs1_pending(o_rs1_pending), .o_rs2_pending(o_rs2_pending),
    .i_cpl_valid(i_cpl_valid), .i_cpl_rd(i_cpl_rd), .i_cpl_data(i_cpl_data),
    .i_wb_slot_free(i_wb_slot_free),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_wb_steal_req(o_wb_steal_req), .o_outstanding(o_outstanding)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every beat must match the head of exp_q
  always @(negedge i_clk) begin
    if (i_rst_n && o_wb_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {32'd0, 27'd0, o_wb_rd}, 64'hFFFF_FFFF);
      end else begin
        check("beat", {27'd0, o_wb_rd, o_wb_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    i_issue_valid = 1'b1;
    i_issue_rd    = rd;
    #1;
    check($sformatf("issue_ready_rd%0d", rd), {63'd0, o_issue_ready}, 64'd1);
    tick();
    i_issue_valid = 1'b0;
    i_issue_rd    = 5'd0;
  endtask

  task automatic complete(input logic [4:0] rd, input logic [31:0] data, input logic slot);
    i_cpl_valid    = 1'b1;
    i_cpl_rd       = rd;
    i_cpl_data     = data;
    i_wb_slot_free = slot;
    if (rd != 5'd0) exp_q.push_back({rd, data});
    tick();
    i_cpl_valid = 1'b0;
    i_cpl_rd    = 5'd0;
    i_cpl_data  = '0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_issue_valid = 1'b0; i_issue_rd = 5'd0;
    i_rs1 = 5'd0; i_rs2 = 5'd0;
    i_cpl_valid = 1'b0; i_cpl_rd = 5'd0; i_cpl_data = '0;
    i_wb_slot_free = 1'b1;
    #1;
    check("rst_wb_valid", {63'd0, o_wb_valid}, 64'd0);
    check("rst_wb_rd", {59'd0, o_wb_rd}, 64'd0);
    check("rst_wb_data", {32'd0, o_wb_data}, 64'd0);
    check("rst_steal", {63'd0, o_wb_steal_req}, 64'd0);
    check("rst_outstanding", {61'd0, o_outstanding}, 64'd0);
    tick(); tick();
    i_rst_n = 1'b1;
    tick();

    // reset / lookup
    issue(5'd5);
    i_rs1 = 5'd5; i_rs2 = 5'd0; #1;
    check("rs1_pending_5", {63'd0, o_rs1_pending}, 64'd1);
    check("rs2_pending_x0", {63'd0, o_rs2_pending}, 64'd0);
    check("outstanding_1", {61'd0, o_outstanding}, 64'd1);

    // basic writeback latency
    complete(5'd5, 32'hDEADBEEF, 1'b1);
`ifndef FROST_INT_WB_BYPASS_EN
    check("lat_n1_valid", {63'd0, o_wb_valid}, 64'd0);
    tick();
`endif
    check("lat_valid", {63'd0, o_wb_valid}, 64'd1);
    check("lat_rd", {59'd0, o_wb_rd}, 64'd5);
    check("lat_data", {32'd0, o_wb_data}, 64'hDEADBEEF);
    check("rs1_cleared_5", {63'd0, o_rs1_pending}, 64'd0);
    check("outstanding_0", {61'd0, o_outstanding}, 64'd0);
    tick();
    check("hold_valid", {63'd0, o_wb_valid}, 64'd0);
    check("hold_data", {32'd0, o_wb_data}, 64'hDEADBEEF);

    // x0 completion is dropped; x0 never pending
    issue(5'd0);
    check("x0_no_count", {61'd0, o_outstanding}, 64'd0);
    complete(5'd0, 32'h55, 1'b1);
    tick(); tick();

    // capacity / WAW
    for (int r = 1; r <= 4; r++) issue(5'(r));
    check("outstanding_4", {61'd0, o_outstanding}, 64'd4);
    i_issue_rd = 5'd6; #1;
    check("full_ready", {63'd0, o_issue_ready}, 64'd0);
    i_issue_rd = 5'd2; #1;
    check("waw_ready", {63'd0, o_issue_ready}, 64'd0);
    complete(5'd2, 32'h22, 1'b1);
`ifndef FROST_INT_WB_BYPASS_EN
    tick();
`endif
    check("outstanding_3", {61'd0, o_outstanding}, 64'd3);
    i_issue_rd = 5'd2; #1;
    check("reuse_ready", {63'd0, o_issue_ready}, 64'd1);
    i_issue_rd = 5'd0;
    complete(5'd1, 32'h11, 1'b1);
    complete(5'd3, 32'h33, 1'b1);
    complete(5'd4, 32'h44, 1'b1);
    tick(); tick();
    check("cap_drained", {61'd0, o_outstanding}, 64'd0);

    // starvation
    issue(5'd10);
    complete(5'd10, 32'hA, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 7)  check("steal_at7", {63'd0, o_wb_steal_req}, 64'd0);
      if (k == 8)  check("steal_at8", {63'd0, o_wb_steal_req}, 64'd1);
      if (k == 10) check("steal_sat", {63'd0, o_wb_steal_req}, 64'd1);
    end
    check("starve_no_beat", {63'd0, o_wb_valid}, 64'd0);
    i_wb_slot_free = 1'b1;
    tick();
    check("starve_pop_valid", {63'd0, o_wb_valid}, 64'd1);
    check("steal_cleared", {63'd0, o_wb_steal_req}, 64'd0);

    // ordering with slot toggling
    issue(5'd7); issue(5'd8); issue(5'd9);
    complete(5'd7, 32'h1, 1'b1);
    complete(5'd8, 32'h2, 1'b0);
    complete(5'd9, 32'h3, 1'b1);
    i_wb_slot_free = 1'b1;
    tick(); tick(); tick();
    check("order_drained", {61'd0, o_outstanding}, 64'd0);
    check("order_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset mid-operation
    issue(5'd11); issue(5'd12); issue(5'd13);
    complete(5'd11, 32'hB1, 1'b0);
    complete(5'd12, 32'hB2, 1'b0);
    complete(5'd13, 32'hB3, 1'b0);
    i_rs1 = 5'd11; i_rs2 = 5'd12; #1;
    check("pre_rst_pending", {63'd0, o_rs1_pending}, 64'd1);
    check("pre_rst_outstanding", {61'd0, o_outstanding}, 64'd3);
    #2;
    i_rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", {63'd0, o_wb_valid}, 64'd0);
    check("mid_rst_outstanding", {61'd0, o_outstanding}, 64'd0);
    check("mid_rst_rs1", {63'd0, o_rs1_pending}, 64'd0);
    check("mid_rst_rs2", {63'd0, o_rs2_pending}, 64'd0);
    tick();
    i_rst_n = 1'b1;
    i_wb_slot_free = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("post_rst_valid", {63'd0, o_wb_valid}, 64'd0);
    check("post_rst_outstanding", {61'd0, o_outstanding}, 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
